// File: rtl/macguffin_decrypt.sv
// -----------------------------------------------------------------------------
// macguffin_decrypt
//   Iterative MacGuffin block decryptor. One Feistel round per clock, 64-bit
//   ciphertext in and 64-bit plaintext out, valid/ready on both sides.
//   The round function is a key XOR, then a fixed 48-bit bit permutation
//   (P-box), then eight 6->2 bit S-boxes that together produce 16 bits.
//   Round keys are fetched from an external store through rk_addr/rk_data.
//   The store must answer in the same cycle. Keys are requested from
//   ROUNDS-1 down to 0.
//
// Optional build macro: MACGUFFIN_DEC_ABORT_EN
//   When this macro is defined, the block gains an 'abort' input. It drops the
//   block in flight (BUSY or DONE) and returns to IDLE on the next edge. Abort
//   has no effect in IDLE.
// -----------------------------------------------------------------------------
module macguffin_decrypt #(
  parameter int ROUNDS = 32,
  parameter int RKW    = 48
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [63:0]                           in_data,
`ifdef MACGUFFIN_DEC_ABORT_EN
  input  logic                                  abort,
`endif
  output logic [((ROUNDS > 1) ? $clog2(ROUNDS) : 1)-1:0] rk_addr,
  input  logic [RKW-1:0]                        rk_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [63:0]                           out_data
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  // S-box contents. Table k sits in slice [k]. Entry j (6-bit select) is
  // bits [2j+1:2j] of that table.
  localparam logic [7:0][127:0] SBOX_TBL = {
    128'hc4a7_1d6e_f352_8b09_7a3f_e0c1_56d8_b92e,   // S7
    128'h6b2e_f183_9d4a_07c5_e3f8_2a61_bd90_4c57,   // S6
    128'h0ff0_a55a_c33c_9669_e11e_b44b_d22d_788f,   // S5
    128'h71c9_e63a_b45d_208f_1f8e_d7c6_a3b2_5e40,   // S4
    128'hd2b4_8e71_3a5c_f069_4b1e_c7a2_96d3_0f58,   // S3
    128'h5e1a_c7b3_0f64_92d8_a6e9_3c17_58f2_b40d,   // S2
    128'h9a5c_63f0_e1b4_2d87_c369_5a0f_b41e_78d2,   // S1
    128'h3c6a_95f0_1e87_d24b_a5c3_0f69_784b_e1d2    // S0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_fsm;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_rk_addr;
  logic [63:0]     r_state;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [RKW-1:0]  w_mix;
  logic [RKW-1:0]  w_pbox;
  logic [15:0]     w_f;
  logic [63:0]     w_round;
  logic            w_accept;
  logic            w_abort;

  // The top three words {y0,y1,y2} feed the F-function together with the key.
  assign w_mix = r_state[63:16] ^ rk_data;

  // P-box: output bit gi takes input bit (29*gi + 11) mod 48. The stride 29 is
  // coprime with 48, so this is a true permutation.
  genvar gi;
  generate
    for (gi = 0; gi < RKW; gi++) begin : g_pbox
      assign w_pbox[gi] = w_mix[(gi * 29 + 11) % RKW];
    end
  endgenerate

  // S-box layer: box gi looks up 6 permuted bits and produces 2 output bits.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sbox
      logic [5:0] w_sel;
      assign w_sel          = w_pbox[6*gi +: 6];
      assign w_f[2*gi +: 2] = SBOX_TBL[gi][{w_sel, 1'b0} +: 2];
    end
  endgenerate

  // Inverse round: {y0,y1,y2,y3} -> {y3 ^ f, y0, y1, y2}.
  assign w_round  = {r_state[15:0] ^ w_f, r_state[63:16]};

  assign w_accept = in_valid && r_in_ready;

`ifdef MACGUFFIN_DEC_ABORT_EN
  assign w_abort  = abort && (r_fsm != IDLE);
`else
  assign w_abort  = 1'b0;
`endif

  // Control FSM. It owns the round counter, key address, state word and both
  // handshake outputs. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_cnt       <= '0;
      r_rk_addr   <= LAST;
      r_state     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_abort) begin
      // Drop the block in flight. Nothing is emitted.
      r_fsm       <= IDLE;
      r_cnt       <= '0;
      r_rk_addr   <= LAST;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= in_data;
            r_cnt      <= '0;
            r_rk_addr  <= LAST;
            r_in_ready <= 1'b0;
            r_fsm      <= BUSY;
          end
        end
        BUSY: begin
          r_state <= w_round;
          if (r_cnt == LAST) begin
            // Last key (index 0) has been used; prefetch index ROUNDS-1 again.
            r_rk_addr   <= LAST;
            r_out_valid <= 1'b1;
            r_fsm       <= DONE;
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_rk_addr <= r_rk_addr - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
            r_fsm       <= IDLE;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_cnt       <= '0;
          r_rk_addr   <= LAST;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_state;
  assign rk_addr   = r_rk_addr;

endmodule
